// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
//
// Scan-test initiator for a chain of mux-D scan flops. Each accepted START
// shifts a parallel pattern into the chain, issues one functional capture
// cycle, then shifts the captured state out into the parallel RESP register.
//
// Optional feature macro: SCAN_CHAIN_CTRL_COMPARE_EN
//   defined     -> EXP_IN is latched on START and PASS = (final RESP == EXP)
//                  is registered at the DONE edge.
//   not defined -> EXP_IN is ignored and PASS is tied to 0.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous, active-high reset (priority over everything)
//   START      in   run request, sampled only while idle
//   PAT_IN     in   [CHAIN_LEN] pattern, captured on the accepting START edge
//   EXP_IN     in   [CHAIN_LEN] expected response, captured with PAT_IN
//   SO         in   scan-out from chain element 0
//   SE         out  scan enable to every chain flop (1 = shift, 0 = capture)
//   SI         out  scan-in to chain element CHAIN_LEN-1
//   BUSY       out  run in progress
//   DONE       out  one-cycle pulse; RESP and PASS valid from here on
//   RESP       out  [CHAIN_LEN] unloaded response, RESP[i] = element i
//   PASS       out  compare result (0 when the compare option is absent)
//   state_dbg  out  [2] current FSM state, for observation only
//
// Handshake: START is a request that is honoured only when BUSY=0 (state
// IDLE, which includes the DONE cycle); requests while BUSY=1 are dropped,
// not queued. DONE is a single-cycle completion pulse with no back-pressure.
// -----------------------------------------------------------------------------
module scan_chain_ctrl #(
    parameter  int CHAIN_LEN = 16,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP,
    output logic                 PASS,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        UNLOAD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] resp_q;
    logic                 se_q;
    logic                 si_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CHAIN_LEN-1:0] resp_next;

    // Unload samples enter at the MSB and drift down, so the k-th sample
    // (post-capture element k) lands in bit k after CHAIN_LEN samples.
    assign resp_next = {SO, resp_q[CHAIN_LEN-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            pat_q  <= '0;
            resp_q <= '0;
            se_q   <= 1'b0;
            si_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        // Bit 0 goes out in the first SHIFT cycle; the rest
                        // is queued in pat_q, lowest bit next.
                        si_q   <= PAT_IN[0];
                        pat_q  <= PAT_IN >> 1;
                        se_q   <= 1'b1;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        se_q  <= 1'b0;
                        si_q  <= 1'b0;
                        state <= CAPTURE;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        si_q  <= pat_q[0];
                        pat_q <= pat_q >> 1;
                    end
                end
                CAPTURE: begin
                    se_q  <= 1'b1;
                    si_q  <= 1'b0;
                    cnt   <= '0;
                    state <= UNLOAD;
                end
                UNLOAD: begin
                    resp_q <= resp_next;
                    if (cnt == LAST) begin
                        se_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic                 pass_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            exp_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            if (state == IDLE && START) begin
                exp_q <= EXP_IN;
            end
            // Compare uses the vector including the final SO sample.
            if (state == UNLOAD && cnt == LAST) begin
                pass_q <= (resp_next == exp_q);
            end
        end
    end

    assign PASS = pass_q;
`else
    logic unused_exp;
    assign unused_exp = ^EXP_IN;
    assign PASS       = 1'b0;
`endif

    assign SE        = se_q;
    assign SI        = si_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RESP      = resp_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
//
// Directed bench for scan_chain_ctrl with CHAIN_LEN=4. A small behavioural
// scan chain (q <= SE ? next_element : D) is attached to SE/SI/SO; D is
// either the element's own Q (hold) or its inverse (invert).
// -----------------------------------------------------------------------------
module tb_scan_chain_ctrl;

    localparam int L = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT signals
    logic         start  = 1'b0;
    logic [L-1:0] pat_in = '0;
    logic [L-1:0] exp_in = '0;
    logic         so;
    logic         se;
    logic         si;
    logic         busy;
    logic         done;
    logic [L-1:0] resp;
    logic         pass;
    logic [1:0]   state_dbg;

    scan_chain_ctrl #(.CHAIN_LEN(L)) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .PAT_IN    (pat_in),
        .EXP_IN    (exp_in),
        .SO        (so),
        .SE        (se),
        .SI        (si),
        .BUSY      (busy),
        .DONE      (done),
        .RESP      (resp),
        .PASS      (pass),
        .state_dbg (state_dbg)
    );

    // Behavioural scan chain: SI enters element L-1, SO is element 0.
    logic [L-1:0] chain    = '0;
    logic         invert_d = 1'b0;
    always @(posedge clk) begin
        if (se) chain <= {si, chain[L-1:1]};
        else    chain <= invert_d ? ~chain : chain;
    end
    assign so = chain[0];

    // Scoreboard counters
    int           n_checks  = 0;
    int           n_fail    = 0;
    logic [L-1:0] last_resp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_pass(input logic p);
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        return p;
`else
        return 1'b0 & p;
`endif
    endfunction

    // One full run started from IDLE, checked cycle by cycle. Returns in
    // the DONE cycle without advancing further. With glitch=1 a START pulse
    // and different PAT_IN/EXP_IN are presented in SHIFT cycle 3.
    task automatic do_run(input string tag, input logic [L-1:0] pat, input logic [L-1:0] expv,
                          input logic [L-1:0] resp_e, input logic pass_e, input logic glitch);
        pat_in = pat;
        exp_in = expv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        pat_in = L'($urandom_range(0, (1 << L) - 1));
        exp_in = ~expv;
        for (int c = 1; c <= L; c++) begin
            if (glitch && c == 3) begin
                start  = 1'b1;
                pat_in = 4'h5;
            end
            chk({tag, " shift se"},   32'(se),   32'd1);
            chk({tag, " shift si"},   32'(si),   32'(pat[c-1]));
            chk({tag, " shift busy"}, 32'(busy), 32'd1);
            chk({tag, " shift done"}, 32'(done), 32'd0);
            chk({tag, " shift resp hold"}, 32'(resp), 32'(last_resp));
            tick();
            start = 1'b0;
        end
        chk({tag, " capture se"},   32'(se),   32'd0);
        chk({tag, " capture si"},   32'(si),   32'd0);
        chk({tag, " capture busy"}, 32'(busy), 32'd1);
        chk({tag, " capture resp hold"}, 32'(resp), 32'(last_resp));
        tick();
        for (int c = 0; c < L; c++) begin
            chk({tag, " unload se"},   32'(se),   32'd1);
            chk({tag, " unload si"},   32'(si),   32'd0);
            chk({tag, " unload busy"}, 32'(busy), 32'd1);
            chk({tag, " unload done"}, 32'(done), 32'd0);
            if (c == 0) chk({tag, " unload resp hold"}, 32'(resp), 32'(last_resp));
            tick();
        end
        chk({tag, " done"},      32'(done), 32'd1);
        chk({tag, " done busy"}, 32'(busy), 32'd0);
        chk({tag, " done se"},   32'(se),   32'd0);
        chk({tag, " resp"},      32'(resp), 32'(resp_e));
        chk({tag, " pass"},      32'(pass), 32'(exp_pass(pass_e)));
        last_resp = resp_e;
    endtask

    initial begin
        // Reset held 2 cycles with START asserted: no run may start.
        rst    = 1'b1;
        start  = 1'b1;
        pat_in = 4'hF;
        tick();
        tick();
        chk("reset se",   32'(se),   32'd0);
        chk("reset si",   32'(si),   32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset resp", 32'(resp), 32'h0);
        chk("reset pass", 32'(pass), 32'd0);
        chk("reset state", 32'(state_dbg), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("post reset busy", 32'(busy), 32'd0);
        chk("post reset se",   32'(se),   32'd0);

        // Hold chain: pattern comes straight back.
        invert_d = 1'b0;
        do_run("hold_a", 4'hA, 4'hA, 4'hA, 1'b1, 1'b0);
        tick();
        chk("hold_a single done", 32'(done), 32'd0);

        // Inverting chain: 3 captures to C.
        invert_d = 1'b1;
        do_run("inv_pass", 4'h3, 4'hC, 4'hC, 1'b1, 1'b0);
        tick();
        do_run("inv_fail", 4'h3, 4'h3, 4'hC, 1'b0, 1'b0);
        tick();

        // START and PAT_IN changes mid-run are ignored.
        invert_d = 1'b0;
        do_run("glitch", 4'h6, 4'h6, 4'h6, 1'b1, 1'b1);
        tick();
        chk("glitch single done", 32'(done), 32'd0);
        chk("glitch no rerun",    32'(busy), 32'd0);

        // Reset in SHIFT cycle 3.
        pat_in = 4'h9;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst se",   32'(se),   32'd0);
        chk("midrst si",   32'(si),   32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst resp", 32'(resp), 32'h0);
        chk("midrst pass", 32'(pass), 32'd0);
        rst       = 1'b0;
        last_resp = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("midrst no done", 32'(done | busy), 32'd0);
        end
        do_run("after_rst", 4'h9, 4'h9, 4'h9, 1'b1, 1'b0);
        tick();

        // Back-to-back: second START lands in the DONE cycle.
        do_run("b2b_first",  4'hC, 4'hC, 4'hC, 1'b1, 1'b0);
        do_run("b2b_second", 4'h5, 4'h5, 4'h5, 1'b1, 1'b0);
        tick();
        chk("b2b single done", 32'(done), 32'd0);
        chk("b2b resp hold",   32'(resp), 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
